// File: rtl/aer_pkg.sv
// aer_pkg
// Shared definitions for the AER spike injector and related scan blocks:
//   - state_t      : injector FSM state encoding
//   - VIRTS_*      : event type codes placed on the scheduler event bus
//   - calc_words() : number of SRAM words needed to hold one time step
package aer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_LATCH,
    ST_SCAN,
    ST_MARK,
    ST_DONE
  } state_t;

  localparam logic [1:0] VIRTS_SPIKE  = 2'b00;
  localparam logic [1:0] VIRTS_TS_END = 2'b01;

  // ceil(neurons / bits_per_word)
  function automatic int calc_words(input int neurons, input int bits_per_word);
    return (neurons + bits_per_word - 1) / bits_per_word;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// lsb_prio_enc
// Combinational lowest-set-bit encoder.
// Ports:
//   vec   : input vector
//   index : position of the lowest set bit (0 when vec is zero)
//   valid : high when any bit of vec is set
module lsb_prio_enc #(
  parameter int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  // Walk from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aer_spike_injector.sv
// aer_spike_injector
// Walks a spike-bitmap SRAM for one frame and pushes one scheduler event per
// set bit, plus one end-of-time-step marker after each time step.
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   START                : one-cycle frame start request (ignored while busy)
//   BUSY, DONE           : frame in progress / one-cycle end-of-frame pulse
//   SPK_MEM_RE/ADDR/DATA : synchronous SRAM read port (data valid next cycle)
//   SCHED_FULL           : scheduler FIFO backpressure
//   CTRL_SCHED_EVENT_IN  : push strobe; an event is accepted when high at the edge
//   CTRL_SCHED_VIRTS     : event type (spike or time-step end)
//   CTRL_SCHED_ADDR      : neuron index for spikes, time-step index for markers
//   EVENT_CNT            : saturating count of spike events pushed this frame
module aer_spike_injector
  import aer_pkg::*;
#(
  parameter int TIME_STEP           = 8,
  parameter int INPUT_NEURON        = 784,
  parameter int PRE_NEUR_ADDR_WIDTH = 10,
  parameter int PRE_NEUR_DATA_WIDTH = 8,
  parameter int SPK_MEM_ADDR_WIDTH  = 10,
  parameter int EVT_CNT_WIDTH       = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           START,
  output logic                           BUSY,
  output logic                           DONE,
  output logic                           SPK_MEM_RE,
  output logic [SPK_MEM_ADDR_WIDTH-1:0]  SPK_MEM_ADDR,
  input  logic [PRE_NEUR_DATA_WIDTH-1:0] SPK_MEM_DATA,
  input  logic                           SCHED_FULL,
  output logic                           CTRL_SCHED_EVENT_IN,
  output logic [1:0]                     CTRL_SCHED_VIRTS,
  output logic [PRE_NEUR_ADDR_WIDTH-1:0] CTRL_SCHED_ADDR,
  output logic [EVT_CNT_WIDTH-1:0]       EVENT_CNT
);

  localparam int WORDS     = calc_words(INPUT_NEURON, PRE_NEUR_DATA_WIDTH);
  // Number of live bits in the final word of each time step.
  localparam int LAST_BITS = INPUT_NEURON - (WORDS - 1) * PRE_NEUR_DATA_WIDTH;
  localparam int W_W       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int T_W       = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam int IDX_W     = (PRE_NEUR_DATA_WIDTH > 1) ? $clog2(PRE_NEUR_DATA_WIDTH) : 1;

  localparam logic [W_W-1:0] W_LAST = W_W'(WORDS - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIME_STEP - 1);

  state_t                           state, state_next;
  logic [T_W-1:0]                   t;
  logic [W_W-1:0]                   w;
  logic [SPK_MEM_ADDR_WIDTH-1:0]    mem_addr;
  logic [PRE_NEUR_DATA_WIDTH-1:0]   word_reg;
  // Running w*PRE_NEUR_DATA_WIDTH so the spike address needs no multiplier.
  logic [PRE_NEUR_ADDR_WIDTH-1:0]   spike_base;
  logic [EVT_CNT_WIDTH-1:0]         event_cnt;

  logic [PRE_NEUR_DATA_WIDTH-1:0]   last_mask;
  logic [IDX_W-1:0]                 enc_idx;
  logic                             enc_valid;

  logic                             push_valid;
  logic [1:0]                       push_virts;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]   push_addr;
  logic                             fire;

  for (genvar i = 0; i < PRE_NEUR_DATA_WIDTH; i++) begin : g_mask
    assign last_mask[i] = (i < LAST_BITS);
  end

  lsb_prio_enc #(
    .WIDTH (PRE_NEUR_DATA_WIDTH)
  ) u_enc (
    .vec   (word_reg),
    .index (enc_idx),
    .valid (enc_valid)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and push decode. The push is purely combinational so an event
  // is either accepted at this edge or still presented next cycle.
  always_comb begin
    state_next = state;
    push_valid = 1'b0;
    push_virts = VIRTS_SPIKE;
    push_addr  = '0;
    case (state)
      ST_IDLE:  if (START) state_next = ST_RD;
      ST_RD:    state_next = ST_LATCH;
      ST_LATCH: state_next = ST_SCAN;
      ST_SCAN: begin
        if (enc_valid) begin
          push_valid = 1'b1;
          push_virts = VIRTS_SPIKE;
          push_addr  = spike_base + PRE_NEUR_ADDR_WIDTH'(enc_idx);
        end else if (w == W_LAST) begin
          state_next = ST_MARK;
        end else begin
          state_next = ST_RD;
        end
      end
      ST_MARK: begin
        push_valid = 1'b1;
        push_virts = VIRTS_TS_END;
        push_addr  = PRE_NEUR_ADDR_WIDTH'(t);
        if (!SCHED_FULL) state_next = (t == T_LAST) ? ST_DONE : ST_RD;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign fire = push_valid & ~SCHED_FULL;

  // Datapath: counters, SRAM address and the word being scanned.
  always_ff @(posedge CLK) begin
    if (RST) begin
      t          <= '0;
      w          <= '0;
      mem_addr   <= '0;
      word_reg   <= '0;
      spike_base <= '0;
      event_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            t          <= '0;
            w          <= '0;
            mem_addr   <= '0;
            spike_base <= '0;
            event_cnt  <= '0;
          end
        end
        ST_LATCH: begin
          word_reg <= (w == W_LAST) ? (SPK_MEM_DATA & last_mask) : SPK_MEM_DATA;
          mem_addr <= mem_addr + SPK_MEM_ADDR_WIDTH'(1);
        end
        ST_SCAN: begin
          if (enc_valid) begin
            if (fire) begin
              // x & (x-1) drops exactly the lowest set bit.
              word_reg <= word_reg & (word_reg - PRE_NEUR_DATA_WIDTH'(1));
              if (event_cnt != '1) event_cnt <= event_cnt + EVT_CNT_WIDTH'(1);
            end
          end else if (w != W_LAST) begin
            w          <= w + W_W'(1);
            spike_base <= spike_base + PRE_NEUR_ADDR_WIDTH'(PRE_NEUR_DATA_WIDTH);
          end
        end
        ST_MARK: begin
          if (fire && (t != T_LAST)) begin
            t          <= t + T_W'(1);
            w          <= '0;
            spike_base <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Every output is forced low while reset is held, even before the first edge.
  assign BUSY                = ~RST & (state != ST_IDLE);
  assign DONE                = ~RST & (state == ST_DONE);
  assign SPK_MEM_RE          = ~RST & (state == ST_RD);
  assign SPK_MEM_ADDR        = (~RST && state == ST_RD) ? mem_addr : '0;
  assign CTRL_SCHED_EVENT_IN = fire & ~RST;
  assign CTRL_SCHED_VIRTS    = RST ? 2'b00 : push_virts;
  assign CTRL_SCHED_ADDR     = RST ? '0 : push_addr;
  assign EVENT_CNT           = RST ? '0 : event_cnt;

endmodule

// File: tb/tb_aer_spike_injector.sv
// tb_aer_spike_injector
// Directed bench for aer_spike_injector. Instance A uses TIME_STEP=2 and a
// behavioural synchronous SRAM; instance B uses TIME_STEP=8 with an all-zero
// memory to check marker sequencing and frame latency.
module tb_aer_spike_injector;

  logic clk = 1'b0;
  logic rst;

  logic       start_a, full_a, busy_a, done_a, re_a, evt_a;
  logic [9:0] mem_addr_a, addr_a;
  logic [7:0] mem_data_a;
  logic [1:0] virts_a;
  logic [15:0] cnt_a;

  logic       start_b, full_b, busy_b, done_b, re_b, evt_b;
  logic [9:0] mem_addr_b, addr_b;
  logic [7:0] mem_data_b;
  logic [1:0] virts_b;
  logic [15:0] cnt_b;

  logic [7:0] mem [0:1023];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;

  logic [1:0] evq_v[$];
  logic [9:0] evq_a[$];
  int         evq_c[$];
  logic [9:0] rdq[$];
  logic [1:0] evq_v_b[$];
  logic [9:0] evq_a_b[$];
  logic [1:0] exp_v[$];
  logic [9:0] exp_a[$];

  always #5 clk = ~clk;

  aer_spike_injector #(.TIME_STEP(2)) dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .BUSY(busy_a), .DONE(done_a),
    .SPK_MEM_RE(re_a), .SPK_MEM_ADDR(mem_addr_a), .SPK_MEM_DATA(mem_data_a),
    .SCHED_FULL(full_a), .CTRL_SCHED_EVENT_IN(evt_a), .CTRL_SCHED_VIRTS(virts_a),
    .CTRL_SCHED_ADDR(addr_a), .EVENT_CNT(cnt_a)
  );

  aer_spike_injector #(.TIME_STEP(8)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .SPK_MEM_RE(re_b), .SPK_MEM_ADDR(mem_addr_b), .SPK_MEM_DATA(mem_data_b),
    .SCHED_FULL(full_b), .CTRL_SCHED_EVENT_IN(evt_b), .CTRL_SCHED_VIRTS(virts_b),
    .CTRL_SCHED_ADDR(addr_b), .EVENT_CNT(cnt_b)
  );

  assign mem_data_b = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (re_a) mem_data_a <= mem[mem_addr_a];
  end

  // Accepted events, DONE pulses and SRAM reads, sampled mid-cycle.
  always @(negedge clk) begin
    if (evt_a) begin
      evq_v.push_back(virts_a);
      evq_a.push_back(addr_a);
      evq_c.push_back(cyc);
    end
    if (re_a) rdq.push_back(mem_addr_a);
    if (done_a) done_cnt_a++;
    if (evt_b) begin
      evq_v_b.push_back(virts_b);
      evq_a_b.push_back(addr_b);
    end
    if (done_b) done_cnt_b++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic waitDoneA(input string tag);
    int n = 0;
    while (!done_a && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, done_a, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitPending29(input string tag);
    int n = 0;
    while (!(busy_a && virts_a == 2'b00 && addr_a == 10'd29) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, addr_a, 29);
  endtask

  task automatic clearRun();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    evq_v.delete(); evq_a.delete(); evq_c.delete(); rdq.delete();
    exp_v.delete(); exp_a.delete();
  endtask

  task automatic compareEvents(input string tag);
    checkOutput({tag, "_count"}, evq_v.size(), exp_v.size());
    for (int i = 0; i < exp_v.size(); i++) begin
      if (i < evq_v.size()) begin
        checkOutput($sformatf("%s_virts%0d", tag, i), evq_v[i], exp_v[i]);
        checkOutput($sformatf("%s_addr%0d", tag, i), evq_a[i], exp_a[i]);
      end
    end
  endtask

  // Expected event list for word 3 = 8'hA0 at t=0 and TIME_STEP=2.
  task automatic expectA0();
    exp_v = '{2'b00, 2'b00, 2'b01, 2'b01};
    exp_a = '{10'd29, 10'd31, 10'd0, 10'd1};
  endtask

  initial begin
    int n;
    int done_before;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; full_a = 1'b0; full_b = 1'b0;
    clearRun();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_re", re_a, 0);
    checkOutput("rst_memaddr", mem_addr_a, 0);
    checkOutput("rst_evt", evt_a, 0);
    checkOutput("rst_cnt", cnt_a, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    rst = 1'b0;

    // Single spike in word 0 of t=0
    clearRun();
    mem[0] = 8'h01;
    done_before = done_cnt_a;
    applyStimulus();
    checkOutput("t1_busy", busy_a, 1);
    waitDoneA("t1_done");
    exp_v = '{2'b00, 2'b01, 2'b01};
    exp_a = '{10'd0, 10'd0, 10'd1};
    compareEvents("t1");
    checkOutput("t1_done_pulses", done_cnt_a - done_before, 1);
    checkOutput("t1_cnt", cnt_a, 1);
    checkOutput("t1_idle", busy_a, 0);

    // Two spikes in word 3, back to back
    clearRun();
    mem[3] = 8'hA0;
    applyStimulus();
    waitDoneA("t2_done");
    expectA0();
    compareEvents("t2");
    if (evq_c.size() >= 2) checkOutput("t2_b2b", evq_c[1] - evq_c[0], 1);
    checkOutput("t2_cnt", cnt_a, 2);

    // Backpressure on a pending spike
    clearRun();
    mem[3] = 8'hA0;
    full_a = 1'b1;
    applyStimulus();
    waitPending29("t3_pending");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t3_hold_evt%0d", k), evt_a, 0);
      checkOutput($sformatf("t3_hold_addr%0d", k), addr_a, 29);
      @(posedge clk); #1;
    end
    full_a = 1'b0;
    #1;
    checkOutput("t3_release_evt", evt_a, 1);
    checkOutput("t3_release_addr", addr_a, 29);
    waitDoneA("t3_done");
    expectA0();
    compareEvents("t3");
    checkOutput("t3_cnt", cnt_a, 2);

    // All-zero frame on the eight-step instance: markers and latency
    evq_v_b.delete(); evq_a_b.delete();
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 1;
    while (!done_b && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t4_latency", n, (98 * 3 + 1) * 8 + 1);
    @(posedge clk); #1;
    checkOutput("t4_markers", evq_v_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < evq_v_b.size()) begin
        checkOutput($sformatf("t4_virts%0d", i), evq_v_b[i], 2'b01);
        checkOutput($sformatf("t4_addr%0d", i), evq_a_b[i], i);
      end
    end
    checkOutput("t4_cnt", cnt_b, 0);
    checkOutput("t4_done_pulses", done_cnt_b, 1);

    // Reset in SCAN with spikes pending, then restart
    clearRun();
    mem[3] = 8'hA0;
    full_a = 1'b1;
    done_before = done_cnt_a;
    applyStimulus();
    waitPending29("t5_pending");
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("t5_busy", busy_a, 0);
    checkOutput("t5_evt", evt_a, 0);
    checkOutput("t5_virts", virts_a, 0);
    checkOutput("t5_addr", addr_a, 0);
    checkOutput("t5_re", re_a, 0);
    checkOutput("t5_done", done_a, 0);
    rst = 1'b0;
    full_a = 1'b0;
    #1;
    checkOutput("t5_idle", busy_a, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_no_done", done_cnt_a - done_before, 0);
    rdq.delete(); evq_v.delete(); evq_a.delete(); evq_c.delete();
    applyStimulus();
    waitDoneA("t5_done_after");
    checkOutput("t5_rd_count", rdq.size(), 196);
    if (rdq.size() > 0) checkOutput("t5_first_rd", rdq[0], 0);
    expectA0();
    compareEvents("t5");
    checkOutput("t5_done_pulses", done_cnt_a - done_before, 1);

    // START re-asserted while busy is ignored
    clearRun();
    mem[0] = 8'h01;
    done_before = done_cnt_a;
    applyStimulus();
    repeat (10) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (200) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    waitDoneA("t6_done");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t6_done_pulses", done_cnt_a - done_before, 1);
    checkOutput("t6_idle", busy_a, 0);
    checkOutput("t6_events", evq_v.size(), 3);
    checkOutput("t6_cnt", cnt_a, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aer_spike_injector.md
Name: aer_spike_injector

Overview:
- Producer end of the scheduler event FIFO. It pushes `{CTRL_SCHED_VIRTS, CTRL_SCHED_ADDR}` events under `CTRL_SCHED_EVENT_IN`, and obeys `SCHED_FULL` as backpressure.
- For one frame it walks a spike-bitmap SRAM holding TIME_STEP × WORDS bytes. Each set bit produces one pre-neuron spike event; each time step ends with one marker event.
- It sits between the input-spike memory and the scheduler, replacing the controller as the event source in open-loop inference and training.

Parameters:
- TIME_STEP, 8, time steps per frame.
- INPUT_NEURON, 784, pre-synaptic neurons per time step.
- PRE_NEUR_ADDR_WIDTH, 10, width of the event address field.
- PRE_NEUR_DATA_WIDTH, 8, spike bits per SRAM word.
- SPK_MEM_ADDR_WIDTH, 10, SRAM address width; must satisfy 2^SPK_MEM_ADDR_WIDTH ≥ TIME_STEP×WORDS.
- EVT_CNT_WIDTH, 16, width of the spike event counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle frame start request.
- BUSY  out  1  high whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse at frame end.
- SPK_MEM_RE  out  1  SRAM read enable; sync SRAM, data valid the next cycle.
- SPK_MEM_ADDR  out  SPK_MEM_ADDR_WIDTH  SRAM word address.
- SPK_MEM_DATA  in  PRE_NEUR_DATA_WIDTH  SRAM read data.
- SCHED_FULL  in  1  scheduler FIFO full.
- CTRL_SCHED_EVENT_IN  out  1  push strobe.
- CTRL_SCHED_VIRTS  out  2  event type.
- CTRL_SCHED_ADDR  out  PRE_NEUR_ADDR_WIDTH  neuron index or time-step index.
- EVENT_CNT  out  EVT_CNT_WIDTH  spike events pushed this frame.

Behaviour:
- Derived constant: WORDS = ceil(INPUT_NEURON / PRE_NEUR_DATA_WIDTH).
- SRAM layout: the word for time step t, word w, is at address t×WORDS+w. A running address counter produces this; no multiplier.
- Event types:
  - VIRTS=2'b00 is a spike; ADDR = w×PRE_NEUR_DATA_WIDTH + bit.
  - VIRTS=2'b01 is the end-of-time-step marker; ADDR = t, zero-extended.
  - Codes 2'b10 and 2'b11 are never emitted.
- Reset: all registers clear and state goes to IDLE. While RST is high, all outputs are 0: BUSY, DONE, RE, ADDR, EVENT_IN, VIRTS, SCHED_ADDR, EVENT_CNT. Reset mid-frame abandons the frame silently; no DONE pulse.
- FSM states:
  - IDLE: on START, clear t, w, mem_addr and EVENT_CNT, then go to RD. START is ignored in every other state.
  - RD: assert RE with SPK_MEM_ADDR = mem_addr, then go to LATCH.
  - LATCH: capture SPK_MEM_DATA into word_reg. In the last word, mask bits at index ≥ INPUT_NEURON − w×PRE_NEUR_DATA_WIDTH. Increment mem_addr. Go to SCAN.
  - SCAN, word_reg ≠ 0: present the lowest set bit as a spike event. If SCHED_FULL=0, EVENT_IN=1, clear that bit, and increment EVENT_CNT (saturating). If SCHED_FULL=1, hold everything unchanged.
  - SCAN, word_reg = 0: if w = WORDS−1, go to MARK; otherwise w++ and go to RD.
  - MARK: present the marker. If SCHED_FULL=0, push it; then, if t = TIME_STEP−1, go to DONE, else t++, w=0, go to RD. If SCHED_FULL=1, hold.
  - DONE: DONE=1 for one cycle, then go to IDLE.
- Push outputs are a combinational decode of registered state, word_reg and SCHED_FULL:
  - CTRL_SCHED_EVENT_IN = push_valid & ~SCHED_FULL & ~RST.
  - An event counts as accepted if and only if EVENT_IN is high at the clock edge.
  - There is no registered push, so no event can be lost when the FIFO fills.
- Throughput:
  - At most one event per cycle.
  - Spike events within a word go out in ascending bit order, back-to-back when not full.
  - An all-zero word costs 3 cycles (RD, LATCH, SCAN).
- EVENT_CNT holds its value after DONE until the next START. It saturates at all-ones.

Decomposition:
- Shared package `aer_pkg`:
  - FSM state encoding (IDLE/RD/LATCH/SCAN/MARK/DONE).
  - VIRTS codes: VIRTS_SPIKE=2'b00, VIRTS_TS_END=2'b01.
  - WORDS calculation function.
- One sub-module: `lsb_prio_enc`, a parameterised lowest-set-bit encoder with outputs index and valid. It is combinational and shared with future scan blocks.

Test Plan:
- TIME_STEP=2, only word 0 of t=0 = 8'h01, SCHED_FULL=0 → events in order {00,0}, {01,0}, {01,1}; DONE pulses once; EVENT_CNT=1.
- t=0, word 3 = 8'hA0 → spike events ADDR 29 then 31 on consecutive cycles, then marker {01,0}.
- SCHED_FULL forced high for 5 cycles while a spike at ADDR 29 is pending → EVENT_IN=0 for those 5 cycles. ADDR stays 29; the push occurs on the first cycle full=0; no duplicate, no loss.
- All-zero frame, TIME_STEP=8, INPUT_NEURON=784 → exactly 8 markers, ADDR 0..7, EVENT_CNT=0. DONE comes (98×3+1)×8+1 cycles after START.
- RST pulsed in SCAN with spikes pending → next cycle all outputs 0 and BUSY=0; a new START restarts from SRAM address 0.
- START re-asserted while BUSY → ignored; the frame completes with exactly one DONE.
